// File: rtl/wb_slave_ram.sv
// Wishbone classic responder: word RAM with byte-lane writes and wait states.
// Define WB_SLAVE_ERR_EN to add o_err, which replaces ack for out-of-range accesses.
`ifndef WB_M2S
`define WB_M2S 70:0
`define WB_S2M 32:0
`define WB_DATA 31:0
`define WB_ADDR 63:32
`define WB_SEL 67:64
`define WB_CYC 68
`define WB_STB 69
`define WB_WE 70
`define WB_ACK 32
`endif

module wb_slave_ram #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [`WB_M2S] i_wb,
  output logic [`WB_S2M] o_wb,
`ifdef WB_SLAVE_ERR_EN
  output logic           o_err,
`endif
  output logic           o_busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_DONE
  } state_t;

  state_t state, nxt;

  logic [3:0]    cnt;
  logic [AW-1:0] a_idx;
  logic          a_in;
  logic          a_we;
  logic [31:0]   a_data;
  logic [3:0]    a_sel;
  logic [31:0]   rdata;
  logic [31:0]   mem [DEPTH];

  logic [31:0]   addr;
  logic          req;
  logic          cap;
  logic          i_in;
  logic [AW-1:0] i_idx;
  logic [AW-1:0] r_idx;
  logic          r_in;
  logic          r_we;
  logic          unused_lo;

  assign addr      = i_wb[`WB_ADDR];
  assign req       = i_wb[`WB_CYC] & i_wb[`WB_STB];
  assign cap       = (state == S_IDLE) & req;
  assign i_idx     = addr[AW+1:2];
  assign i_in      = addr[31:AW+2] == BASE_ADDR[31:AW+2];
  assign unused_lo = ^addr[1:0];

  // In IDLE the request goes straight to ACK without waits, so
  // the RAM read must use the live bus rather than the captured copy.
  assign r_idx = (state == S_IDLE) ? i_idx : a_idx;
  assign r_in  = (state == S_IDLE) ? i_in : a_in;
  assign r_we  = (state == S_IDLE) ? i_wb[`WB_WE] : a_we;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (req) nxt = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
      S_WAIT: begin
        if (!i_wb[`WB_CYC]) nxt = S_IDLE;
        else if (cnt == '0) nxt = S_ACK;
      end
      S_ACK:  nxt = S_DONE;
      S_DONE: if (!i_wb[`WB_STB] || !i_wb[`WB_CYC]) nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      rdata <= '0;
    end else begin
      state <= nxt;
      if (cap && WAIT_STATES != 0)
        cnt <= 4'(WAIT_STATES - 1);
      else if (state == S_WAIT && cnt != '0)
        cnt <= cnt - 4'd1;
      if (nxt == S_ACK && !r_we)
        rdata <= r_in ? mem[r_idx] : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (cap) begin
      a_idx  <= i_idx;
      a_in   <= i_in;
      a_we   <= i_wb[`WB_WE];
      a_data <= i_wb[`WB_DATA];
      a_sel  <= i_wb[`WB_SEL];
    end
  end

  // Commit happens on the edge leaving ACK; a reset edge drops it.
  always_ff @(posedge i_clk) begin
    if (!i_rst && state == S_ACK && a_we && a_in) begin
      for (int i = 0; i < 4; i++)
        if (a_sel[i]) mem[a_idx][8*i +: 8] <= a_data[8*i +: 8];
    end
  end

  always_comb begin
    o_wb           = '0;
    o_wb[`WB_DATA] = rdata;
`ifdef WB_SLAVE_ERR_EN
    o_wb[`WB_ACK]  = (state == S_ACK) & a_in;
`else
    o_wb[`WB_ACK]  = (state == S_ACK);
`endif
  end

`ifdef WB_SLAVE_ERR_EN
  assign o_err = (state == S_ACK) & ~a_in;
`endif

  assign o_busy = (state != S_IDLE);

endmodule

// File: doc/wb_slave_ram.md
Name: wb_slave_ram

Overview:
Wishbone classic responder: the target end of the bus driven by the core's Wishbone master. Holds a word-organised RAM with byte-lane writes, an optional fixed wait-state count, and a single-pulse ack that is safe against the master's registered stb drop. It sits behind the master as instruction/data scratch memory or as a template for peripheral slaves.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, minimum 4
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*DEPTH
WAIT_STATES, 0, extra cycles inserted between request capture and ack; range 0..15

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst  input  1  reset, synchronous, active-high
i_wb  input  [`WB_M2S]  master-to-slave bundle; fields `addr, `data, `sel, `cyc, `stb, `we
o_wb  output  [`WB_S2M]  slave-to-master bundle; fields `data (read data), `ack
o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (i_rst high at an edge): state=IDLE; o_wb[`ack]=0; o_wb[`data]=0; wait counter=0. RAM contents are not cleared. Reset overrides any in-flight access; the access is dropped with no ack, and a pending write that has not reached ACK is not committed.
- Request: valid when i_wb[`cyc] & i_wb[`stb]. Sampled only in IDLE.
- Decode: in range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH. Word index = (addr-BASE_ADDR)[log2(DEPTH)+1:2]. addr[1:0] is ignored.
- FSM:
  IDLE: on request, capture addr/data/sel/we into internal registers. If WAIT_STATES=0, go to ACK; otherwise load counter=WAIT_STATES-1 and go to WAIT.
  WAIT: counter decrements each cycle. At 0, go to ACK. If cyc drops in WAIT, abort to IDLE with no write and no ack.
  ACK: o_wb[`ack]=1 for exactly this cycle. Write: for each sel[i]=1, commit byte lane i on the transition edge out of ACK. Read: o_wb[`data] holds RAM word (all 4 lanes, sel ignored), valid in the ACK cycle. Next state DONE.
  DONE: ack=0. Stay until stb=0 or cyc=0, then go to IDLE. This blocks a second ack for a request that is still asserted because the master drops stb one cycle after the ack.
- Latency: ack is asserted 1+WAIT_STATES cycles after the first cycle stb is sampled. Minimum spacing between back-to-back accesses is 3+WAIT_STATES cycles.
- o_wb[`data] holds the last read value until the next read ack. It is not modified by writes.
- Out-of-range access: ack is still generated with normal timing (no bus hang). Writes are discarded; reads return 32'h0000_0000.
- sel=4'b0000 write: acked, no RAM change.
- Read after write to the same word: returns the new data. The write commits at ACK exit, before any subsequent IDLE capture.

Optional Feature:
Macro WB_SLAVE_ERR_EN.
- Defined: adds output port o_err (1 bit, reset 0). For out-of-range accesses, the ACK state pulses o_err=1 instead of o_wb[`ack]; timing, DONE handling and write discard are unchanged.
- Undefined: no o_err port; out-of-range accesses ack normally as specified above.

Test Plan:
- WAIT_STATES=0, write addr 0x10 data 0xA5A5_1234 sel 4'hF, then read 0x10 -> ack 1 cycle after stb each time; read data 0xA5A5_1234; exactly one ack pulse per access.
- Byte lanes: write 0xFFFF_FFFF to 0x20, then write 0x0000_0000 with sel 4'b0101, read 0x20 -> 0xFF00_FF00.
- WAIT_STATES=3: read 0x04 -> ack exactly 4 cycles after stb; o_busy high from the capture edge until return to IDLE.
- Master holds stb for 3 cycles after ack -> no second ack, FSM stays in DONE until stb=0; next request is accepted normally.
- Out-of-range read at BASE_ADDR+4*DEPTH -> ack with data 0x0000_0000 (with WB_SLAVE_ERR_EN: o_err pulse, no ack). Out-of-range write leaves word 0 unchanged.
- i_rst asserted in WAIT during a write to 0x30 (old value 0x1111_1111) -> no ack, ack=0 and data=0 after reset, read of 0x30 returns 0x1111_1111.
